// File: rtl/ma_job_sequencer_32.sv
// Matrix accelerator job sequencer: packs operand windows, starts the job, returns the result.
// Optional watchdog on the accelerator wait is enabled by defining MA_SEQ_TIMEOUT_EN.
module ma_job_sequencer_32 #(
    parameter int KERNEL_SIZE    = 3,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = $clog2(KERNEL_SIZE**4),
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                       Clk,
    input  logic                                       Rst,
    input  logic [DATA_WIDTH-1:0]                      s_data,
    input  logic                                       s_valid,
    output logic                                       s_ready,
    input  logic [ADDR_WIDTH-1:0]                      cfg_addr,
    input  logic                                       cfg_direct,
    input  logic                                       flush,
    output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] multiplier_input,
    output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] multiplicand_input,
    output logic [ADDR_WIDTH-1:0]                      AddressSelect,
    output logic                                       direct,
    output logic [KERNEL_SIZE*KERNEL_SIZE-1:0]         mStart,
    input  logic [DATA_WIDTH-1:0]                      finalAccumulate,
    input  logic                                       finalReady,
    output logic [DATA_WIDTH-1:0]                      r_data,
    output logic                                       r_valid,
    input  logic                                       r_ready,
    output logic                                       busy,
    output logic [15:0]                                job_count,
    output logic                                       timeout_err
);

    localparam int N  = KERNEL_SIZE * KERNEL_SIZE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [2:0] {
        ST_LOAD_A,
        ST_LOAD_B,
        ST_START,
        ST_WAIT,
        ST_RESULT
    } state_t;

    state_t        st;
    state_t        nxt;
    logic [CW-1:0] cnt;
    logic          fr_q;
    logic          fr_edge;
    logic          hs;
    logic          last;
    logic          tmo;

    assign hs      = s_valid & s_ready;
    assign last    = (cnt == LAST);
    assign fr_edge = finalReady & ~fr_q;

`ifdef MA_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;

    // Counter is zero whenever outside WAIT, so every WAIT entry starts fresh.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            tcnt <= '0;
        end else if (st != ST_WAIT || flush) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + 1'b1;
        end
    end

    assign tmo = (st == ST_WAIT) && (tcnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            timeout_err <= 1'b0;
        end else if (flush) begin
            timeout_err <= 1'b0;
        end else if (tmo && !fr_edge) begin
            timeout_err <= 1'b1;
        end
    end
`else
    assign tmo         = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            st <= ST_LOAD_A;
        end else begin
            st <= nxt;
        end
    end

    always_comb begin
        nxt = st;
        if (flush) begin
            nxt = ST_LOAD_A;
        end else begin
            unique case (st)
                ST_LOAD_A: if (hs && last) nxt = ST_LOAD_B;
                ST_LOAD_B: if (hs && last) nxt = ST_START;
                ST_START:  nxt = ST_WAIT;
                ST_WAIT: begin
                    if (fr_edge) begin
                        nxt = ST_RESULT;
                    end else if (tmo) begin
                        nxt = ST_LOAD_A;
                    end
                end
                ST_RESULT: if (r_ready) nxt = ST_LOAD_A;
                default:   nxt = ST_LOAD_A;
            endcase
        end
    end

    always_comb begin
        s_ready = Rst && !flush && (st == ST_LOAD_A || st == ST_LOAD_B);
        mStart  = {N{st == ST_START}};
        busy    = !(st == ST_LOAD_A && cnt == '0);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            cnt                <= '0;
            fr_q               <= 1'b0;
            multiplier_input   <= '0;
            multiplicand_input <= '0;
            AddressSelect      <= '0;
            direct             <= 1'b0;
            r_data             <= '0;
            r_valid            <= 1'b0;
            job_count          <= '0;
        end else begin
            fr_q <= finalReady;
            if (flush) begin
                cnt     <= '0;
                r_valid <= 1'b0;
            end else begin
                if (hs) begin
                    for (int i = 0; i < N; i++) begin
                        if (cnt == CW'(i)) begin
                            if (st == ST_LOAD_A) begin
                                multiplier_input[DATA_WIDTH*i +: DATA_WIDTH] <= s_data;
                            end else begin
                                multiplicand_input[DATA_WIDTH*i +: DATA_WIDTH] <= s_data;
                            end
                        end
                    end
                    if (st == ST_LOAD_A && cnt == '0) begin
                        AddressSelect <= cfg_addr;
                        direct        <= cfg_direct;
                    end
                    cnt <= last ? '0 : cnt + 1'b1;
                end
                if (st == ST_WAIT && fr_edge) begin
                    r_data    <= finalAccumulate;
                    r_valid   <= 1'b1;
                    job_count <= job_count + 1'b1;
                end
                if (st == ST_RESULT && r_ready) begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

endmodule
